sadd_ser: RTL and testbench

- Upstream operand serializer for the bit-serial adder. It accepts two parallel W-bit operands on a start request.
- It drives them LSB-first on x/y, one bit per clock, then appends one flush cycle with x=y=0.
- The flush cycle makes the adder emit the carry-out as sum bit W and returns its carry state to zero, so consecutive additions need no adder reset.
- Its x and y outputs connect directly to the adder's x and y; both blocks share clk and rst_b.

---
 rtl/sadd_ser.sv | 98 +++++++++
 tb/tb_sadd_ser.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sadd_ser.sv
// Operand serializer for the bit-serial adder.
// Shifts two W-bit operands out LSB-first, then adds one flush cycle with x=y=0.
// The flush cycle lets the adder emit its carry-out and leaves its carry at zero.
module sadd_ser #(
    parameter int unsigned W = 8
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       start,
    input  logic [W-1:0]               a,
    input  logic [W-1:0]               b,
    output logic                       ready,
    output logic                       busy,
    output logic                       x,
    output logic                       y,
    output logic                       bit_vld,
    output logic [$clog2(W+1)-1:0]     idx,
    output logic                       last
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    sa, sa_nxt;
    logic [W-1:0]    sb, sb_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    // State and operand shift registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sa    <= sa_nxt;
            sb    <= sb_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state/datapath and output decode from registered state only
    always_comb begin
        state_nxt = state;
        sa_nxt    = sa;
        sb_nxt    = sb;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        busy      = 1'b0;
        x         = 1'b0;
        y         = 1'b0;
        bit_vld   = 1'b0;
        idx       = '0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    sa_nxt    = a;
                    sb_nxt    = b;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                bit_vld = 1'b1;
                x       = sa[0];
                y       = sb[0];
                idx     = cnt;
                sa_nxt  = sa >> 1;
                sb_nxt  = sb >> 1;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                busy      = 1'b1;
                bit_vld   = 1'b1;
                last      = 1'b1;
                idx       = CW'(W);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sadd_ser.sv
// Directed bench for sadd_ser (W=4) with a bit-serial adder model on x/y.
module tb_sadd_ser;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk;
    logic          rst_b;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          busy;
    logic          x;
    logic          y;
    logic          bit_vld;
    logic [CW-1:0] idx;
    logic          last;

    int n_checks = 0;
    int n_errors = 0;

    sadd_ser #(.W(W)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .x       (x),
        .y       (y),
        .bit_vld (bit_vld),
        .idx     (idx),
        .last    (last)
    );

    // Clock: negedges at 5,15,25..., posedges at 10,20,...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Downstream bit-serial adder model sharing clk/rst_b
    logic c;
    logic z;
    assign z = x ^ y ^ c;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) c <= 1'b0;
        else        c <= (x & y) | (x & c) | (y & c);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"},   32'(ready),   32'd1);
        check({tag, ".busy"},    32'(busy),    32'd0);
        check({tag, ".x"},       32'(x),       32'd0);
        check({tag, ".y"},       32'(y),       32'd0);
        check({tag, ".bit_vld"}, 32'(bit_vld), 32'd0);
        check({tag, ".idx"},     32'(idx),     32'd0);
        check({tag, ".last"},    32'(last),    32'd0);
    endtask

    // Wait (bounded) for ready, then request an operation; returns at idx=0 negedge
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        int k = 0;
        while (ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("wait_ready", 32'(ready), 32'd1);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
    endtask

    // Check W+1 bit cycles then the following IDLE cycle.
    // pulse_at: cycle where start is pulsed with other operands; hold: leave start alone.
    task automatic run_bits(input string tag, input logic [4:0] ex, input logic [4:0] ey,
                            input logic [4:0] ez, input int pulse_at, input bit hold);
        for (int i = 0; i <= int'(W); i++) begin
            if (!hold) begin
                start = (i == pulse_at);
                if (i == pulse_at) begin
                    a = 4'hA;
                    b = 4'hC;
                end
            end
            check($sformatf("%s.x%0d", tag, i),    32'(x),       32'(ex[i]));
            check($sformatf("%s.y%0d", tag, i),    32'(y),       32'(ey[i]));
            check($sformatf("%s.z%0d", tag, i),    32'(z),       32'(ez[i]));
            check($sformatf("%s.idx%0d", tag, i),  32'(idx),     32'(i));
            check($sformatf("%s.last%0d", tag, i), 32'(last),    32'(i == int'(W)));
            check($sformatf("%s.vld%0d", tag, i),  32'(bit_vld), 32'd1);
            check($sformatf("%s.busy%0d", tag, i), 32'(busy),    32'd1);
            check($sformatf("%s.rdy%0d", tag, i),  32'(ready),   32'd0);
            @(negedge clk);
        end
        check_idle({tag, ".end"});
        check({tag, ".carry"}, 32'(c), 32'd0);
    endtask

    initial begin
        rst_b = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3;
        check_idle("in_reset");
        #22;
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        // 5 + 3 = 8
        start_op(4'b0101, 4'b0011);
        run_bits("op53", 5'b00101, 5'b00011, 5'b01000, -1, 1'b0);

        // F + F = 30
        start_op(4'hF, 4'hF);
        run_bits("opFF", 5'b01111, 5'b01111, 5'b11110, -1, 1'b0);

        // Back-to-back: start held high, second op after one IDLE cycle, no stale carry
        start_op(4'hF, 4'hF);
        a = 4'h1;
        b = 4'h0;
        run_bits("b2b1", 5'b01111, 5'b01111, 5'b11110, -1, 1'b1);
        @(negedge clk);
        run_bits("b2b2", 5'b00001, 5'b00000, 5'b00001, -1, 1'b0);

        // start pulsed during SHIFT is ignored
        start_op(4'b0101, 4'b0011);
        run_bits("pulse", 5'b00101, 5'b00011, 5'b01000, 1, 1'b0);

        // Reset asserted at idx=2 of F+F
        start_op(4'hF, 4'hF);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_pre.x%0d", i),   32'(x),   32'd1);
            check($sformatf("rst_pre.idx%0d", i), 32'(idx), 32'(i));
            if (i < 2) @(negedge clk);
        end
        rst_b = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset.carry", 32'(c), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // 2 + 1 = 3
        start_op(4'h2, 4'h1);
        run_bits("op21", 5'b00010, 5'b00001, 5'b00011, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
